e1rxfr: RTL and testbench

E1 receive framer: the receive-direction counterpart of the E1 transmit framer. Accepts the 2.048 Mb/s NRZ bit stream from the HDB3 decoder, one bit per clk2 cycle, and searches for G.706 frame alignment (FAS/NFAS in TS0). Once aligned, it deserializes the stream into timeslot-tagged bytes for the VC/VT mapping side. Bit order is MSB first: the first received bit of a timeslot is byte bit 7, matching the transmit serializer.

---
 rtl/e1rxfr_pkg.sv | 19 +
 rtl/e1rxfr_tsc.sv | 48 ++++
 rtl/fflopx.sv | 16 +
 rtl/e1rxfr.sv | 113 +++++++++++
 tb/tb_e1rxfr.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/e1rxfr_pkg.sv
// Shared E1 receive framer definitions: frame alignment pattern, frame size
// and framer state encoding.
package e1rxfr_pkg;

    localparam logic [6:0] FAS_PAT       = 7'b0011011;
    localparam int         E1_TS_PER_FRM = 32;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_NFASCHK = 2'd1,
        ST_FASCHK  = 2'd2,
        ST_SYNC    = 2'd3
    } fr_state_e;

    function automatic logic is_fas(input logic [7:0] cb);
        return cb[6:0] == FAS_PAT;
    endfunction

endpackage

// File: rtl/e1rxfr_tsc.sv
// Bit / timeslot / frame-parity counter for the E1 receive framer; a load
// re-anchors it on the bit after a FAS candidate (start of timeslot 1).
module e1rxtsc
    import e1rxfr_pkg::*;
(
    input  logic       clk2,
    input  logic       rst,
    input  logic       load,
    output logic [2:0] bitcnt,
    output logic [4:0] tscnt,
    output logic       fasfrm
);

    logic [2:0] bitcnt_q, bitcnt_d;
    logic [4:0] tscnt_q, tscnt_d;
    logic       fasfrm_q, fasfrm_d;

    always_comb begin
        bitcnt_d = bitcnt_q + 3'd1;
        tscnt_d  = tscnt_q;
        fasfrm_d = fasfrm_q;
        if (load) begin
            bitcnt_d = 3'd0;
            tscnt_d  = 5'd1;
            fasfrm_d = 1'b0;
        end else if (bitcnt_q == 3'd7) begin
            tscnt_d = (tscnt_q == 5'(E1_TS_PER_FRM - 1)) ? 5'd0 : tscnt_q + 5'd1;
            if (tscnt_q == 5'd0) fasfrm_d = ~fasfrm_q;
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            bitcnt_q <= 3'd0;
            tscnt_q  <= 5'd0;
            fasfrm_q <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            tscnt_q  <= tscnt_d;
            fasfrm_q <= fasfrm_d;
        end
    end

    assign bitcnt = bitcnt_q;
    assign tscnt  = tscnt_q;
    assign fasfrm = fasfrm_q;

endmodule

// File: rtl/fflopx.sv
// Generic W-bit register with synchronous active-high reset to zero.
module fflopx #(
    parameter int W = 1
) (
    input  logic         clk2,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk2) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/e1rxfr.sv
// E1 receive framer: G.706 FAS/NFAS alignment search and MSB-first
// deserialisation into timeslot-tagged bytes.
//
//   state      | meaning
//   HUNT       | test every bit position for FAS
//   NFASCHK    | candidate found, expect NFAS bit6=1 one frame later
//   FASCHK     | expect FAS again two frames after the candidate
//   SYNC       | aligned, emit bytes, count consecutive FAS errors
module e1rxfr
    import e1rxfr_pkg::*;
#(
    parameter int WID   = 8,
    parameter int LOSSN = 3
) (
    input  logic           clk2,
    input  logic           rst,
    input  logic           serin,
    output logic [WID-1:0] dataout,
    output logic           dovld,
    output logic [4:0]     tsnum,
    output logic           frmsync,
    output logic           ferr
);

    localparam int ECW = $clog2(LOSSN + 1);

    fr_state_e      state_q, state_d;
    logic [ECW-1:0] errcnt_q, errcnt_d;
    logic [WID-1:0] sr_q, sr_d;
    logic [WID-1:0] cb;
    logic [WID-1:0] dataout_d;
    logic [4:0]     tsnum_d;
    logic           dovld_d, frmsync_d, ferr_d;
    logic           tsc_load, fas_ok, byte_end, ts0_end;
    logic [2:0]     bitcnt;
    logic [4:0]     tscnt;
    logic           fasfrm;

    e1rxtsc u_tsc (
        .clk2   (clk2),
        .rst    (rst),
        .load   (tsc_load),
        .bitcnt (bitcnt),
        .tscnt  (tscnt),
        .fasfrm (fasfrm)
    );

    always_comb begin
        cb        = {sr_q[WID-2:0], serin};
        sr_d      = cb;
        fas_ok    = is_fas(cb);
        byte_end  = (bitcnt == 3'd7);
        ts0_end   = byte_end && (tscnt == 5'd0);
        state_d   = state_q;
        errcnt_d  = errcnt_q;
        ferr_d    = 1'b0;
        tsc_load  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (fas_ok) begin
                    tsc_load = 1'b1;
                    state_d  = ST_NFASCHK;
                end
            end
            ST_NFASCHK: begin
                if (ts0_end) state_d = cb[6] ? ST_FASCHK : ST_HUNT;
            end
            ST_FASCHK: begin
                if (ts0_end) state_d = fas_ok ? ST_SYNC : ST_HUNT;
            end
            ST_SYNC: begin
                if (ts0_end && fasfrm) begin
                    if (fas_ok) begin
                        errcnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                        if (errcnt_q == ECW'(LOSSN - 1)) begin
                            state_d  = ST_HUNT;
                            errcnt_d = '0;
                        end else begin
                            errcnt_d = errcnt_q + ECW'(1);
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
        // A TS0 byte that coincides with loss of alignment is dropped.
        dovld_d   = (state_q == ST_SYNC) && byte_end && (state_d == ST_SYNC);
        frmsync_d = (state_d == ST_SYNC);
        dataout_d = dovld_d ? cb : dataout;
        tsnum_d   = dovld_d ? tscnt : tsnum;
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            errcnt_q <= '0;
            sr_q     <= '0;
        end else begin
            state_q  <= state_d;
            errcnt_q <= errcnt_d;
            sr_q     <= sr_d;
        end
    end

    fflopx #(.W(WID)) u_dataout (.clk2(clk2), .rst(rst), .d(dataout_d), .q(dataout));
    fflopx #(.W(5))   u_tsnum   (.clk2(clk2), .rst(rst), .d(tsnum_d),   .q(tsnum));
    fflopx #(.W(1))   u_dovld   (.clk2(clk2), .rst(rst), .d(dovld_d),   .q(dovld));
    fflopx #(.W(1))   u_frmsync (.clk2(clk2), .rst(rst), .d(frmsync_d), .q(frmsync));
    fflopx #(.W(1))   u_ferr    (.clk2(clk2), .rst(rst), .d(ferr_d),    .q(ferr));

endmodule

// File: tb/tb_e1rxfr.sv
// Directed bench for the E1 receive framer; the line stream is generated from
// a source bit index so expected bytes, timeslots and event times follow it.
module tb_e1rxfr;

    logic       clk2 = 1'b0;
    logic       rst = 1'b1;
    logic       serin = 1'b0;
    logic [7:0] dataout;
    logic       dovld;
    logic [4:0] tsnum;
    logic       frmsync;
    logic       ferr;

    e1rxfr #(.WID(8), .LOSSN(3)) dut (
        .clk2    (clk2),
        .rst     (rst),
        .serin   (serin),
        .dataout (dataout),
        .dovld   (dovld),
        .tsnum   (tsnum),
        .frmsync (frmsync),
        .ferr    (ferr)
    );

    always #5 clk2 = ~clk2;

    int          checks = 0;
    int          errors = 0;
    int          src = 0;
    int          src_last = -1;
    logic [63:0] bad_mask = '0;
    int          inj_frame = -1;
    logic        chk_data = 1'b1;
    int          ferr_cnt = 0;
    int          last_ferr = -1;
    int          rise_src = -1;
    int          fall_src = -1;
    int          dv_cnt = 0;
    int          first_dv_src = -1;
    int          snap = 0;
    logic        prev_sync = 1'b0;

    // Byte index bi -> frame bi/32, timeslot bi%32. Even frames carry FAS.
    function automatic logic [7:0] byte_of(input int bi);
        int f;
        int ts;
        f  = bi / 32;
        ts = bi % 32;
        if (ts == 0) begin
            if (f % 2 == 1) return 8'h40;
            if (f < 64 && bad_mask[f]) return 8'h00;
            return 8'h1B;
        end
        if (ts == 5 && f == inj_frame) return 8'h1B;
        return 8'(ts);
    endfunction

    function automatic logic bit_of(input int p);
        logic [7:0] b;
        b = byte_of(p / 8);
        return b[7 - (p % 8)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        serin = bit_of(src);
        @(posedge clk2);
        src_last = src;
        src      = src + 1;
        #1;
        if (ferr === 1'b1) begin
            ferr_cnt++;
            last_ferr = src_last;
        end
        if (frmsync === 1'b1 && !prev_sync) rise_src = src_last;
        if (frmsync !== 1'b1 && prev_sync)  fall_src = src_last;
        prev_sync = (frmsync === 1'b1);
        if (dovld === 1'b1) begin
            dv_cnt++;
            if (first_dv_src < 0) first_dv_src = src_last;
            chk("dv_while_sync", 32'(frmsync), 32'd1);
            if (chk_data) begin
                chk("dv_phase", 32'(src_last % 8), 32'd7);
                chk("dv_tsnum", 32'(tsnum), 32'((src_last / 8) % 32));
                chk("dv_data", 32'(dataout), 32'(byte_of(src_last / 8)));
            end
        end
    endtask

    task automatic run_to(input int t);
        while (src_last < t) step();
    endtask

    task automatic restart(input int s);
        src      = s;
        src_last = s - 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dataout"}, 32'(dataout), 32'd0);
        chk({tag, "_dovld"},   32'(dovld),   32'd0);
        chk({tag, "_tsnum"},   32'(tsnum),   32'd0);
        chk({tag, "_frmsync"}, 32'(frmsync), 32'd0);
        chk({tag, "_ferr"},    32'(ferr),    32'd0);
    endtask

    initial begin
        bad_mask[4]  = 1'b1;
        bad_mask[6]  = 1'b1;
        bad_mask[10] = 1'b1;
        bad_mask[12] = 1'b1;
        bad_mask[16] = 1'b1;
        bad_mask[18] = 1'b1;
        bad_mask[20] = 1'b1;

        // Reset
        rst = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        prev_sync = 1'b0;

        // Clean acquisition: FAS at src 7, NFAS at 263, FAS at 519.
        restart(0);
        run_to(1023);
        chk("acq_rise", 32'(rise_src), 32'd519);
        chk("acq_first_dv", 32'(first_dv_src), 32'd527);
        chk("acq_dv_count", 32'(dv_cnt), 32'd63);
        chk("acq_sync", 32'(frmsync), 32'd1);

        // Two bad FAS, one good, two bad again: no loss.
        run_to(1543);
        chk("err2_ferr", 32'(ferr_cnt), 32'd2);
        chk("err2_last", 32'(last_ferr), 32'd1543);
        chk("err2_sync", 32'(frmsync), 32'd1);
        run_to(2055);
        chk("good_ferr", 32'(ferr_cnt), 32'd2);
        run_to(3079);
        chk("clr_ferr", 32'(ferr_cnt), 32'd4);
        chk("clr_sync", 32'(frmsync), 32'd1);
        run_to(4095);
        chk("clr_nofall", 32'(fall_src), 32'hFFFF_FFFF);

        // Three consecutive bad FAS: loss at src 5127, relock at 6151.
        run_to(5126);
        chk("loss_pre_ferr", 32'(ferr_cnt), 32'd6);
        chk("loss_pre_sync", 32'(frmsync), 32'd1);
        snap = dv_cnt;
        run_to(5127);
        chk("loss_ferr", 32'(ferr_cnt), 32'd7);
        chk("loss_ferr_pulse", 32'(ferr), 32'd1);
        chk("loss_fall", 32'(fall_src), 32'd5127);
        chk("loss_dovld", 32'(dovld), 32'd0);
        chk("loss_hold", 32'(dataout), 32'd31);
        run_to(6158);
        chk("relock_rise", 32'(rise_src), 32'd6151);
        chk("relock_nodv", 32'(dv_cnt), 32'(snap));
        run_to(6159);
        chk("relock_dv", 32'(dv_cnt), 32'(snap + 1));
        chk("relock_ts", 32'(tsnum), 32'd1);

        // One-bit slip in SYNC: three ferr, loss at 7688, relock at 8711.
        run_to(6480);
        src = src + 1;
        chk_data = 1'b0;
        run_to(6664);
        chk("slip_ferr1", 32'(last_ferr), 32'd6664);
        run_to(7688);
        chk("slip_ferr", 32'(ferr_cnt), 32'd10);
        chk("slip_fall", 32'(fall_src), 32'd7688);
        chk("slip_sync", 32'(frmsync), 32'd0);
        chk_data = 1'b1;
        snap = dv_cnt;
        run_to(8711);
        chk("slip_rise", 32'(rise_src), 32'd8711);
        chk("slip_nodv", 32'(dv_cnt), 32'(snap));
        run_to(8799);
        chk("slip_dv_count", 32'(dv_cnt), 32'(snap + 11));

        // Reset mid-frame in SYNC, relock at 9735.
        run_to(8806);
        rst = 1'b1;
        step();
        chk_zero("midrst");
        rst = 1'b0;
        snap = dv_cnt;
        run_to(9735);
        chk("midrst_rise", 32'(rise_src), 32'd9735);
        chk("midrst_nodv", 32'(dv_cnt), 32'(snap));
        run_to(9743);
        chk("midrst_dv", 32'(dv_cnt), 32'(snap + 1));
        chk("midrst_data", 32'(dataout), 32'd1);

        // False FAS in TS5 of frame 41: NFAS fails, true lock at 11783.
        rst = 1'b1;
        step();
        rst = 1'b0;
        inj_frame = 41;
        restart(41 * 256);
        snap = dv_cnt;
        run_to(11783);
        chk("false_rise", 32'(rise_src), 32'd11783);
        chk("false_nodv", 32'(dv_cnt), 32'(snap));
        run_to(11791);
        chk("false_dv_ts", 32'(tsnum), 32'd1);
        chk("false_dv", 32'(dovld), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
